// File: rtl/div_iter_r2.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter_r2
//  Description : Iterative radix-2 restoring divider, signed or unsigned,
//                one quotient bit per cycle; result = {remainder, quotient}.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_iter_r2 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sign,
    input  logic                 opn_valid,
    input  logic                 res_ready,
    output logic                 res_valid,
    output logic [2*WIDTH-1:0]   result
);

    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_bmag;
    logic               r_sa;
    logic               r_sb;
    logic [2*WIDTH-1:0] r_result;

    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_amag;
    logic [WIDTH-1:0]   w_bmag;
    logic [WIDTH:0]     w_trial;
    logic               w_trial_neg;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic               w_last;

    // Operand magnitudes; only meaningful in the acceptance cycle.
    assign w_sa   = sign & a[WIDTH-1];
    assign w_sb   = sign & b[WIDTH-1];
    assign w_amag = w_sa ? -a : a;
    assign w_bmag = w_sb ? -b : b;

    // One restoring step: the dividend bits shift out of Q into R while the
    // quotient bits shift into Q from the bottom.
    assign w_trial     = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_bmag};
    assign w_trial_neg = w_trial[WIDTH];
    assign w_rem_nxt   = w_trial_neg ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]}
                                     : w_trial[WIDTH-1:0];
    assign w_quo_nxt   = {r_quo[WIDTH-2:0], ~w_trial_neg};

    // Quotient truncates toward zero, remainder follows the dividend sign.
    assign w_quo_fix   = (r_sa ^ r_sb) ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix   = r_sa ? -w_rem_nxt : w_rem_nxt;
    assign w_last      = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Dropping opn_valid outranks completion, so a flushed op never reports.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (opn_valid) begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!opn_valid) begin
                    w_next_state = S_IDLE;
                end else if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (!opn_valid || res_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_bmag   <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (opn_valid) begin
                        r_cnt  <= '0;
                        r_rem  <= '0;
                        r_quo  <= w_amag;
                        r_bmag <= w_bmag;
                        r_sa   <= w_sa;
                        r_sb   <= w_sb;
                    end
                end
                S_BUSY: begin
                    if (opn_valid) begin
                        r_cnt <= r_cnt + c_ONE;
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        if (w_last) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign res_valid = (r_state == S_DONE);
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_iter_r2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_iter_r2
//  Description : Self-checking bench for div_iter_r2 with a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter_r2;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sign;
    logic           opn_valid;
    logic           res_ready;
    logic           res_valid;
    logic [2*W-1:0] result;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [63:0]    exp_q[$];

    always #5 clk = ~clk;

    div_iter_r2 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .sign      (sign),
        .opn_valid (opn_valid),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .result    (result)
    );

    // Reference: native SV arithmetic plus the defined corner cases.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (!s) begin
            if (y == 32'd0) begin
                q = 32'hFFFF_FFFF;
                r = x;
            end else begin
                q = x / y;
                r = x % y;
            end
        end else begin
            if (y == 32'd0) begin
                q = x[31] ? 32'd1 : 32'hFFFF_FFFF;
                r = x;
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
            end
        end
        return {r, q};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (res_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                         output int lat, output logic [63:0] res, output logic post);
        a         = x;
        b         = y;
        sign      = s;
        opn_valid = 1'b1;
        res_ready = 1'b1;
        wait_valid(lat);
        res = result;
        tick();
        post      = res_valid;
        opn_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        opn_valid = 1'b1;
        res_ready = 1'b1;
        a         = 32'd100;
        b         = 32'd7;
        sign      = 1'b0;
        tick();
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", res_valid);
        end
        n_checks++;
        if (result !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 0", result);
        end
        opn_valid = 1'b0;
        rst       = 1'b0;
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected 0", res_valid);
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] ta [3] = '{32'd100, 32'hFFFF_FFFF, 32'h1234_5678};
        logic [31:0] tb [3] = '{32'd7,   32'd1,         32'h0000_0100};
        logic [63:0] te [3] = '{64'h0000_0002_0000_000E, 64'h0000_0000_FFFF_FFFF,
                                64'h0000_0078_0012_3456};
        int          lat;
        logic [63:0] res;
        logic [63:0] exp;
        logic        post;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(te[i]);
            do_op(ta[i], tb[i], 1'b0, lat, res, post);
            exp = exp_q.pop_front();
            n_checks++;
            if (lat != 33) begin
                n_fail++;
                $display("FAIL unsigned_latency[%0d]: got %0d expected 33", i, lat);
            end
            n_checks++;
            if (res !== exp) begin
                n_fail++;
                $display("FAIL unsigned_result[%0d]: got %h expected %h", i, res, exp);
            end
            n_checks++;
            if (post !== 1'b0) begin
                n_fail++;
                $display("FAIL unsigned_idle[%0d]: got %b expected 0", i, post);
            end
        end
    endtask

    task automatic test_signed();
        logic [31:0] ta [3] = '{32'hFFFF_FFF9, 32'd7,         32'h8000_0000};
        logic [31:0] tb [3] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [63:0] te [3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_FFFF_FFFD,
                                64'h0000_0000_8000_0000};
        int          lat;
        logic [63:0] res;
        logic [63:0] exp;
        logic        post;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(te[i]);
            do_op(ta[i], tb[i], 1'b1, lat, res, post);
            exp = exp_q.pop_front();
            n_checks++;
            if (lat != 33) begin
                n_fail++;
                $display("FAIL signed_latency[%0d]: got %0d expected 33", i, lat);
            end
            n_checks++;
            if (res !== exp) begin
                n_fail++;
                $display("FAIL signed_result[%0d]: got %h expected %h", i, res, exp);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] ta [3] = '{32'd7, 32'hFFFF_FFF9, 32'd9};
        logic        ts [3] = '{1'b0,  1'b1,          1'b1};
        logic [63:0] te [3] = '{64'h0000_0007_FFFF_FFFF, 64'hFFFF_FFF9_0000_0001,
                                64'h0000_0009_FFFF_FFFF};
        int          lat;
        logic [63:0] res;
        logic [63:0] exp;
        logic        post;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(te[i]);
            do_op(ta[i], 32'd0, ts[i], lat, res, post);
            exp = exp_q.pop_front();
            n_checks++;
            if (res !== exp) begin
                n_fail++;
                $display("FAIL divzero_result[%0d]: got %h expected %h", i, res, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [63:0] exp;
        exp_q.push_back(model(32'h1234_5678, 32'h0000_009A, 1'b0));
        a         = 32'h1234_5678;
        b         = 32'h0000_009A;
        sign      = 1'b0;
        opn_valid = 1'b1;
        res_ready = 1'b0;
        wait_valid(lat);
        exp = exp_q.pop_front();
        n_checks++;
        if (lat != 33) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d expected 33", lat);
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (res_valid !== 1'b1 || result !== exp) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b result=%h expected valid=1 result=%h",
                         k, res_valid, result, exp);
            end
            tick();
        end
        res_ready = 1'b1;
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got %b expected 0", res_valid);
        end
        opn_valid = 1'b0;
        tick();
    endtask

    task automatic test_abort_done();
        int          lat;
        logic [63:0] exp;
        exp_q.push_back(model(32'd1000, 32'd33, 1'b1));
        a         = 32'd1000;
        b         = 32'd33;
        sign      = 1'b1;
        opn_valid = 1'b1;
        res_ready = 1'b0;
        wait_valid(lat);
        exp = exp_q.pop_front();
        opn_valid = 1'b0;
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_abort_valid: got %b expected 0", res_valid);
        end
        n_checks++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL done_abort_result: got %h expected %h", result, exp);
        end
        res_ready = 1'b1;
    endtask

    task automatic test_operand_change();
        int          lat;
        logic [63:0] exp;
        exp_q.push_back(model(32'hDEAD_BEEF, 32'h0000_1234, 1'b1));
        a         = 32'hDEAD_BEEF;
        b         = 32'h0000_1234;
        sign      = 1'b1;
        opn_valid = 1'b1;
        res_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            a    = $urandom;
            b    = $urandom;
            sign = 1'($urandom_range(0, 1));
            tick();
        end
        wait_valid(lat);
        exp = exp_q.pop_front();
        n_checks++;
        if (lat < 0 || lat + 6 != 33) begin
            n_fail++;
            $display("FAIL opchange_latency: got %0d expected 33", lat + 6);
        end
        n_checks++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL opchange_result: got %h expected %h", result, exp);
        end
        tick();
        opn_valid = 1'b0;
    endtask

    task automatic test_abort_reset();
        int          lat;
        logic [63:0] exp;
        a         = 32'd100;
        b         = 32'd7;
        sign      = 1'b0;
        opn_valid = 1'b1;
        res_ready = 1'b1;
        tick();
        repeat (10) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_abort_valid: got %b expected 0", res_valid);
        end
        rst = 1'b0;
        exp_q.push_back(64'h0000_0002_0000_000E);
        wait_valid(lat);
        exp = exp_q.pop_front();
        n_checks++;
        if (lat != 33) begin
            n_fail++;
            $display("FAIL rst_restart_latency: got %0d expected 33", lat);
        end
        n_checks++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL rst_restart_result: got %h expected %h", result, exp);
        end
        tick();
        opn_valid = 1'b0;
    endtask

    task automatic test_abort_opn();
        int          lat;
        logic [63:0] res;
        logic [63:0] exp;
        logic        post;
        logic        seen;
        a         = 32'hFFFF_0000;
        b         = 32'd3;
        sign      = 1'b0;
        opn_valid = 1'b1;
        res_ready = 1'b1;
        tick();
        repeat (8) tick();
        opn_valid = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (res_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL opn_abort_valid: got %b expected 0", seen);
        end
        exp_q.push_back(model(32'h0BAD_F00D, 32'd17, 1'b0));
        do_op(32'h0BAD_F00D, 32'd17, 1'b0, lat, res, post);
        exp = exp_q.pop_front();
        n_checks++;
        if (lat != 33 || res !== exp) begin
            n_fail++;
            $display("FAIL opn_abort_restart: got lat=%0d result=%h expected lat=33 result=%h",
                     lat, res, exp);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [63:0] exp;
        logic [31:0] na;
        logic [31:0] nb;
        logic        ns;
        res_ready = 1'b1;
        opn_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            na = $urandom;
            nb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            ns = 1'(i % 2);
            a    = na;
            b    = nb;
            sign = ns;
            exp_q.push_back(model(na, nb, ns));
            wait_valid(lat);
            exp = exp_q.pop_front();
            n_checks++;
            if (lat != 33) begin
                n_fail++;
                $display("FAIL b2b_latency[%0d]: got %0d expected 33", i, lat);
            end
            n_checks++;
            if (result !== exp) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got %h expected %h", i, result, exp);
            end
            tick();
            n_checks++;
            if (res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_single[%0d]: got %b expected 0", i, res_valid);
            end
        end
        opn_valid = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_backpressure();
        test_abort_done();
        test_operand_change();
        test_abort_reset();
        test_abort_opn();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
